// File: rtl/lut4_cfg_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lut4_cfg_loader: serial (MSB-first) writer for an SRL16-style 4-in LUT  |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module lut4_cfg_loader #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        busy,
  output logic        done,
  input  logic        I0,
  input  logic        I1,
  input  logic        I2,
  input  logic        I3,
  output logic        LO,
  output logic [15:0] cfg
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cfg_q, cfg_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= INIT;
      hold_q  <= 16'h0000;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid && load_ready) begin
          hold_d  = load_data;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Partially shifted contents are visible on LO; consumers gate with !busy.
        cfg_d  = {cfg_q[14:0], hold_q[15]};
        hold_d = {hold_q[14:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE) && !reset;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign cfg        = cfg_q;
  assign LO         = cfg_q[{I3, I2, I1, I0}];

endmodule
`default_nettype wire

// File: tb/tb_lut4_cfg_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_lut4_cfg_loader: randomized + directed bench with a behavioural model |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_lut4_cfg_loader;

  localparam logic [15:0] INIT = 16'h8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] load_data = 16'h0000;
  logic        load_valid = 1'b0;
  logic        load_ready, busy, done, LO;
  logic [3:0]  addr = 4'h0;
  logic [15:0] cfg;

  int total = 0;
  int bad   = 0;

  lut4_cfg_loader #(.INIT(INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .busy       (busy),
    .done       (done),
    .I0         (addr[0]),
    .I1         (addr[1]),
    .I2         (addr[2]),
    .I3         (addr[3]),
    .LO         (LO),
    .cfg        (cfg)
  );

  always #5 clk = ~clk;

  // Behavioural model: a load in flight is described by the old table, the
  // new word and how many bits have entered so far.
  logic [15:0] m_base = INIT;
  logic [15:0] m_word = 16'h0000;
  int          m_k = 0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_base   = INIT;
      m_active = 1'b0;
      m_k      = 0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == 16) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_base   = m_word;
          m_k      = 0;
        end
      end else if (load_valid) begin
        m_active = 1'b1;
        m_word   = load_data;
        m_k      = 0;
      end
    end
  end

  function automatic logic [15:0] model_cfg();
    logic [31:0] t;
    if (!m_active) return m_base;
    t = ({16'h0000, m_base} << m_k) | ({16'h0000, m_word} >> (16 - m_k));
    return t[15:0];
  endfunction

  task automatic accept(input logic [15:0] word);
    @(negedge clk);
    load_data  = word;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h1357;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", load_ready); end
    end
    load_valid = 1'b0;
    reset = 1'b0;
    addr = 4'hF;
    #1;
    total++;
    if (cfg !== INIT) begin bad++; $display("FAIL reset_cfg got=%h want=%h", cfg, INIT); end
    total++;
    if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", load_ready); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    total++;
    if (LO !== 1'b1) begin bad++; $display("FAIL reset_LO_F got=%b want=1", LO); end
    addr = 4'h0;
    #1;
    total++;
    if (LO !== 1'b0) begin bad++; $display("FAIL reset_LO_0 got=%b want=0", LO); end
  endtask

  task automatic test_single();
    logic [15:0] w = 16'hA5C3;
    int busy_cnt = 0;
    int done_cnt = 0;
    accept(w);
    for (int i = 0; i <= 17; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        total++;
        if (i != 16) begin bad++; $display("FAIL single_done_time got=%0d want=16", i); end
      end
      total++;
      if (cfg !== model_cfg()) begin bad++; $display("FAIL single_cfg i=%0d got=%h want=%h", i, cfg, model_cfg()); end
    end
    total++;
    if (busy_cnt != 16) begin bad++; $display("FAIL single_busy_cycles got=%0d want=16", busy_cnt); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    total++;
    if (cfg !== 16'hA5C3) begin bad++; $display("FAIL single_cfg_final got=%h want=a5c3", cfg); end
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      total++;
      if (LO !== w[a]) begin bad++; $display("FAIL single_LO addr=%0d got=%b want=%b", a, LO, w[a]); end
    end
  endtask

  task automatic test_ignored_valid();
    int done_cnt = 0;
    accept(16'h1234);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (i == 4) begin
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
      end else begin
        load_valid = 1'b0;
      end
    end
    total++;
    if (cfg !== 16'h1234) begin bad++; $display("FAIL ignored_cfg got=%h want=1234", cfg); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int first_done = -1;
    int second_done = -1;
    @(negedge clk);
    load_data  = 16'h00FF;
    load_valid = 1'b1;
    @(negedge clk);
    load_data = 16'hFF00;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
      if (i == 16) begin
        total++;
        if (load_ready !== 1'b1 || done !== 1'b1 || cfg !== 16'h00FF) begin
          bad++; $display("FAIL b2b_done_cycle got ready=%b done=%b cfg=%h want 1 1 00ff", load_ready, done, cfg);
        end
      end
      if (i == 17) begin
        load_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got busy=%b want=1", busy); end
      end
    end
    total++;
    if (cfg !== 16'hFF00) begin bad++; $display("FAIL b2b_cfg got=%h want=ff00", cfg); end
    total++;
    if (first_done != 16 || second_done != 33) begin
      bad++; $display("FAIL b2b_done_spacing got=%0d,%0d want=16,33", first_done, second_done);
    end
  endtask

  task automatic test_intermediate();
    accept(16'h0000);
    repeat (17) @(negedge clk);
    addr = 4'h0;
    accept(16'hFFFF);
    #1;
    total++;
    if (cfg !== 16'h0000 || LO !== 1'b0) begin bad++; $display("FAIL inter_k0 got cfg=%h LO=%b want 0000 0", cfg, LO); end
    for (int k = 1; k <= 16; k++) begin
      logic [31:0] e;
      @(negedge clk);
      #1;
      e = (32'd1 << k) - 32'd1;
      total++;
      if (cfg !== e[15:0]) begin bad++; $display("FAIL inter_cfg k=%0d got=%h want=%h", k, cfg, e[15:0]); end
      total++;
      if (LO !== 1'b1) begin bad++; $display("FAIL inter_LO k=%0d got=%b want=1", k, LO); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int loads = 0;
    int cyc = 0;
    logic [15:0] e;
    while (loads < 8 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      addr = 4'($urandom_range(0, 15));
      #1;
      e = model_cfg();
      total++;
      if (cfg !== e) begin bad++; $display("FAIL rand_cfg cyc=%0d got=%h want=%h", cyc, cfg, e); end
      total++;
      if (LO !== e[addr]) begin bad++; $display("FAIL rand_LO cyc=%0d addr=%0d got=%b want=%b", cyc, addr, LO, e[addr]); end
      total++;
      if (busy !== m_active || done !== m_done || load_ready !== !m_active) begin
        bad++; $display("FAIL rand_flags cyc=%0d got busy=%b done=%b ready=%b want %b %b %b",
                        cyc, busy, done, load_ready, m_active, m_done, !m_active);
      end
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if (load_valid && !m_active) loads++;
    end
    load_valid = 1'b0;
    repeat (18) @(negedge clk);
    total++;
    if (cfg !== m_base || busy !== 1'b0) begin bad++; $display("FAIL rand_final got cfg=%h busy=%b want %h 0", cfg, busy, m_base); end
  endtask

  task automatic test_mid_reset();
    int done_cnt = 0;
    accept(16'h5555);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (cfg !== INIT) begin bad++; $display("FAIL midrst_cfg got=%h want=%h", cfg, INIT); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done); end
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    total++;
    if (done_cnt != 0 || cfg !== INIT) begin bad++; $display("FAIL midrst_after got activity=%0d cfg=%h want 0 %h", done_cnt, cfg, INIT); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_valid();
    test_back_to_back();
    test_intermediate();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
